// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register FIFO: opcodes, stored word layout, mode encoding.
package instr_register_pkg;

    // Container widths of the stored word; narrower instances sign-extend into them.
    localparam int IW_OP_W  = 32;
    localparam int IW_RES_W = 64;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t                    opc;
        logic signed [IW_OP_W-1:0]  op_a;
        logic signed [IW_OP_W-1:0]  op_b;
        logic signed [IW_RES_W-1:0] result;
    } instr_word_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational write-path ALU: opcode and signed operands to a sign-extended result.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 64
) (
    input  opcode_t                      opcode,
    input  logic signed [OP_WIDTH-1:0]   a,
    input  logic signed [OP_WIDTH-1:0]   b,
    output logic signed [RES_WIDTH-1:0]  result,
    output logic                         div_zero
);

    logic signed [RES_WIDTH-1:0] ae;
    logic signed [RES_WIDTH-1:0] be;

    // Operating at result width keeps MULT exact and MIN/-1 division representable.
    always_comb begin
        ae       = RES_WIDTH'(a);
        be       = RES_WIDTH'(b);
        result   = '0;
        div_zero = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = ae;
            PASSB: result = be;
            ADD:   result = ae + be;
            SUB:   result = ae - be;
            MULT:  result = ae * be;
            DIV:   if (b == '0) div_zero = 1'b1; else result = ae / be;
            MOD:   if (b == '0) div_zero = 1'b1; else result = ae % be;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_fifo.sv
// Instruction register array with addressed and circular-FIFO access; result computed at write.
module instr_register_fifo
    import instr_register_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 64,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fifo_mode,
    input  logic                       load_en,
    input  opcode_t                    opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic [PTR_W-1:0]           write_pointer,
    input  logic [PTR_W-1:0]           read_pointer,
    input  logic                       rd_en,
    output instr_word_t                instruction_word,
    output logic                       rd_valid,
    output logic [PTR_W:0]             count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       div_zero
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (RES_WIDTH < 2 * OP_WIDTH || OP_WIDTH > IW_OP_W || RES_WIDTH > IW_RES_W) begin : g_bad_width
        $error("operand/result widths incompatible with instr_word_t");
    end

    instr_word_t                mem [DEPTH];
    logic [PTR_W-1:0]           wptr, rptr, wr_addr, rd_addr;
    logic                       mode_q, toggle;
    logic                       wr_ok, rd_ok, ovf_c, unf_c;
    logic signed [RES_WIDTH-1:0] alu_res;
    logic                       alu_dz;
    instr_word_t                new_word;

    instr_alu #(.OP_WIDTH(OP_WIDTH), .RES_WIDTH(RES_WIDTH)) u_alu (
        .opcode   (opcode),
        .a        (operand_a),
        .b        (operand_b),
        .result   (alu_res),
        .div_zero (alu_dz)
    );

    assign full   = (mode_q == MODE_FIFO) && (count == (PTR_W+1)'(DEPTH));
    assign empty  = (mode_q == MODE_FIFO) && (count == '0);
    assign toggle = (fifo_mode != mode_q);

    always_comb begin
        new_word.opc    = opcode;
        new_word.op_a   = IW_OP_W'(operand_a);
        new_word.op_b   = IW_OP_W'(operand_b);
        new_word.result = IW_RES_W'(alu_res);
    end

    // A mode switch cycle swallows all requests while pointers are cleared.
    always_comb begin
        wr_ok   = 1'b0;
        rd_ok   = 1'b0;
        ovf_c   = 1'b0;
        unf_c   = 1'b0;
        wr_addr = write_pointer;
        rd_addr = read_pointer;
        if (!toggle) begin
            if (mode_q == MODE_FIFO) begin
                wr_addr = wptr;
                rd_addr = rptr;
                rd_ok   = rd_en && !empty;
                wr_ok   = load_en && (!full || rd_ok);
                ovf_c   = load_en && !wr_ok;
                unf_c   = rd_en && empty;
            end else begin
                rd_ok = rd_en;
                wr_ok = load_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr             <= '0;
            rptr             <= '0;
            count            <= '0;
            mode_q           <= fifo_mode;
            instruction_word <= '0;
            rd_valid         <= 1'b0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
            div_zero         <= 1'b0;
        end else begin
            mode_q    <= fifo_mode;
            rd_valid  <= rd_ok;
            overflow  <= ovf_c;
            underflow <= unf_c;
            div_zero  <= wr_ok && alu_dz;
            if (wr_ok) mem[wr_addr] <= new_word;
            if (rd_ok) instruction_word <= mem[rd_addr];
            if (toggle) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else if (mode_q == MODE_FIFO) begin
                if (wr_ok) wptr <= wptr + 1'b1;
                if (rd_ok) rptr <= rptr + 1'b1;
                count <= count + (PTR_W+1)'(wr_ok) - (PTR_W+1)'(rd_ok);
            end
        end
    end

endmodule

// File: tb/tb_instr_register_fifo.sv
// Directed bench for instr_register_fifo with hand-computed expectations.
module tb_instr_register_fifo;
    import instr_register_pkg::*;

    logic               clk, reset, fifo_mode, load_en, rd_en;
    opcode_t            opcode;
    logic signed [31:0] operand_a, operand_b;
    logic [4:0]         write_pointer, read_pointer;
    instr_word_t        instruction_word;
    logic               rd_valid, full, empty, overflow, underflow, div_zero;
    logic [5:0]         count;

    int n_cmp = 0;
    int n_err = 0;

    instr_register_fifo dut (
        .clk(clk), .reset(reset), .fifo_mode(fifo_mode), .load_en(load_en),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer), .rd_en(rd_en),
        .instruction_word(instruction_word), .rd_valid(rd_valid), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
        .div_zero(div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_word_t mk(opcode_t o, int a, int b, longint r);
        instr_word_t w;
        w.opc    = o;
        w.op_a   = 32'(a);
        w.op_b   = 32'(b);
        w.result = 64'(r);
        return w;
    endfunction

    task automatic drv(input logic le, input opcode_t o, input int a, input int b,
                       input logic re);
        load_en   = le;
        opcode    = o;
        operand_a = 32'(a);
        operand_b = 32'(b);
        rd_en     = re;
    endtask

    initial begin
        reset = 1'b1; fifo_mode = 1'b0; write_pointer = '0; read_pointer = '0;
        drv(1'b0, ZERO, 0, 0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;

        // traffic before a mid-run reset
        write_pointer = 5'd3; drv(1'b1, ADD, 1, 1, 1'b0); cyc();
        read_pointer = 5'd3;  drv(1'b0, ZERO, 0, 0, 1'b1); cyc();
        chk("pre_reset_read", instruction_word, mk(ADD, 1, 1, 2));
        reset = 1'b1; drv(1'b1, DIV, 4, 0, 1'b1);
        cyc(); cyc();
        chk("rst_word", instruction_word, '0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty_addr", empty, 0);
        chk("rst_pulses", {overflow, underflow, div_zero}, 0);
        reset = 1'b0; drv(1'b0, ZERO, 0, 0, 1'b1); read_pointer = 5'd3; cyc();
        chk("rst_entry_cleared", instruction_word, mk(ZERO, 0, 0, 0));
        chk("rst_read_valid", rd_valid, 1);

        // addressed-mode arithmetic
        write_pointer = 5'd3; drv(1'b1, ADD, 7, -2, 1'b0); cyc();
        chk("dz_add", div_zero, 0);
        chk("rd_valid_idle", rd_valid, 0);
        write_pointer = 5'd4; drv(1'b1, MULT, -3, 5, 1'b0); cyc();
        write_pointer = 5'd5; drv(1'b1, DIV, 9, 0, 1'b0); cyc();
        chk("dz_pulse", div_zero, 1);
        drv(1'b0, ZERO, 0, 0, 1'b1); read_pointer = 5'd3; cyc();
        chk("dz_clear", div_zero, 0);
        chk("addr_rd3", instruction_word, mk(ADD, 7, -2, 5));
        chk("addr_rd3_valid", rd_valid, 1);
        read_pointer = 5'd4; cyc();
        chk("addr_rd4", instruction_word, mk(MULT, -3, 5, -15));
        read_pointer = 5'd5; cyc();
        chk("addr_rd5", instruction_word, mk(DIV, 9, 0, 0));
        drv(1'b0, ZERO, 0, 0, 1'b0); cyc();
        chk("hold_valid", rd_valid, 0);
        chk("hold_word", instruction_word, mk(DIV, 9, 0, 0));
        write_pointer = 5'd6; drv(1'b1, MOD, -7, 3, 1'b0); cyc();
        write_pointer = 5'd6; read_pointer = 5'd6; drv(1'b1, PASSB, 0, 22, 1'b1); cyc();
        chk("no_bypass_old", instruction_word, mk(MOD, -7, 3, -1));
        drv(1'b0, ZERO, 0, 0, 1'b1); cyc();
        chk("no_bypass_new", instruction_word, mk(PASSB, 0, 22, 22));
        chk("addr_flags", {count, full, empty, overflow, underflow}, 0);

        // FIFO fill and overflow
        fifo_mode = 1'b1; drv(1'b0, ZERO, 0, 0, 1'b0); cyc();
        chk("fifo_entry_empty", {count, full, empty}, {6'd0, 1'b0, 1'b1});
        for (int i = 0; i < 32; i++) begin
            drv(1'b1, SUB, i, 1, 1'b0); cyc();
            if (i == 30) chk("fill31", {count, full}, {6'd31, 1'b0});
        end
        chk("fill_full", {count, full, empty}, {6'd32, 1'b1, 1'b0});
        drv(1'b1, ADD, 100, 100, 1'b0); cyc();
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 32);
        drv(1'b0, ZERO, 0, 0, 1'b0); cyc();
        chk("ovf_clear", overflow, 0);

        // drain with ordered results, then underflow
        for (int i = 0; i < 32; i++) begin
            drv(1'b0, ZERO, 0, 0, 1'b1); cyc();
            chk("drain_res", instruction_word.result, 64'(i - 1));
            chk("drain_valid", rd_valid, 1);
        end
        chk("drained_empty", {count, empty}, {6'd0, 1'b1});
        cyc();
        chk("unf_pulse", underflow, 1);
        chk("unf_no_valid", rd_valid, 0);
        chk("unf_hold", instruction_word, mk(SUB, 31, 1, 30));
        drv(1'b0, ZERO, 0, 0, 1'b0); cyc();
        chk("unf_clear", underflow, 0);
        for (int i = 1; i <= 3; i++) begin
            drv(1'b1, ADD, i, 10, 1'b0); cyc();
        end
        for (int i = 1; i <= 3; i++) begin
            drv(1'b0, ZERO, 0, 0, 1'b1); cyc();
            chk("wrap_res", instruction_word, mk(ADD, i, 10, i + 10));
        end

        // simultaneous read/write when full and when empty
        for (int i = 0; i < 32; i++) begin
            drv(1'b1, PASSA, 200 + i, 0, 1'b0); cyc();
        end
        drv(1'b1, PASSB, 0, 999, 1'b1); cyc();
        chk("full_rw_count", {count, full}, {6'd32, 1'b1});
        chk("full_rw_oldest", instruction_word, mk(PASSA, 200, 0, 200));
        chk("full_rw_no_ovf", overflow, 0);
        for (int i = 1; i < 32; i++) begin
            drv(1'b0, ZERO, 0, 0, 1'b1); cyc();
            if (i == 31) chk("full_rw_tail", instruction_word.result, 64'd231);
        end
        cyc();
        chk("full_rw_new_slot", instruction_word, mk(PASSB, 0, 999, 999));
        chk("empty_again", empty, 1);
        drv(1'b1, PASSA, 77, 0, 1'b1); cyc();
        chk("empty_rw_count", count, 1);
        chk("empty_rw_unf", underflow, 1);
        chk("empty_rw_valid", rd_valid, 0);
        drv(1'b0, ZERO, 0, 0, 1'b1); cyc();
        chk("empty_rw_read", instruction_word, mk(PASSA, 77, 0, 77));

        // mode toggle keeps storage; FIFO entries land in slots 5..9
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, PASSA, 50 + i, 0, 1'b0); cyc();
        end
        chk("five_count", count, 5);
        fifo_mode = 1'b0; write_pointer = 5'd5; read_pointer = 5'd0;
        drv(1'b1, ZERO, 0, 0, 1'b1); cyc();
        chk("toggle_ignored", {count, rd_valid, empty}, 0);
        drv(1'b0, ZERO, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            read_pointer = 5'(5 + i); cyc();
            chk("toggle_retained", instruction_word, mk(PASSA, 50 + i, 0, 50 + i));
        end
        fifo_mode = 1'b1; drv(1'b0, ZERO, 0, 0, 1'b0); cyc();
        chk("toggle_back", {count, full, empty}, {6'd0, 1'b0, 1'b1});
        drv(1'b0, ZERO, 0, 0, 1'b1); cyc();
        chk("toggle_back_unf", {underflow, rd_valid}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
